gouram_trace_stream: RTL and testbench
======================================

// Module: gouram_trace_stream
// PURPOSE
// - Builds trace records {instruction, mem_addr, t_start, t_end} from start/end events and timestamps them with an internal free-running counter.
// - Buffers the records in a FIFO and emits each one as a sequence of TDATA_WIDTH beats on a valid/ready stream.
// - Sits between the core-side trace tracker and the trace sink (DMA/AXI-Stream bridge); all widths and the FIFO depth are parameters.
// PARAMETERS
// - INSTR_DATA_WIDTH  32  instruction word width
// - DATA_ADDR_WIDTH   32  memory address width
// - TIME_WIDTH        32  timestamp counter width
// - TDATA_WIDTH       32  output beat width
// - FIFO_DEPTH        8   record slots; must be a power of two, >=2
// PORTS
// - clk               in   1     clock
// - rst_n             in   1     async active-low reset
// - ev_start          in   1     pulse: tracked transaction begins; latch ev_instr and ev_addr
// - ev_instr          in   INSTR_DATA_WIDTH  instruction word, sampled on ev_start
// - ev_addr           in   DATA_ADDR_WIDTH   data address, sampled on ev_start
// - ev_end            in   1     pulse: tracked transaction completes
// - m_tvalid          out  1     beat valid
// - m_tready          in   1     sink accepts the beat
// - m_tdata           out  TDATA_WIDTH  beat data
// - m_tlast           out  1     final beat of a record
// - overflow          out  1     sticky: at least one record dropped because the FIFO was full
// - proto_err         out  1     sticky: ev_start while OPEN, or ev_end while IDLE
// - drop_count        out  16    records dropped (port present only with GOURAM_TRACE_DROP_CNT_EN)
// BEHAVIOUR
// - Reset (async, rst_n=0): timestamp=0, FSM=IDLE, FIFO empty, beat index=0; m_tvalid, m_tlast, overflow, proto_err=0; m_tdata=0; drop_count=0. Any open record and any partially sent record are discarded.
// - Timestamp: +1 every cycle; wraps modulo 2^TIME_WIDTH; no wrap flag.
// - FSM IDLE: ev_start -> OPEN; latch instr, addr, t_start=timestamp. ev_end alone -> set proto_err, stay IDLE.
// - FSM OPEN: ev_end -> push {instr, addr, t_start, t_end=timestamp}.
//   - ev_end with ev_start in the same cycle: push the old record, open a new one with t_start = the same timestamp; stay OPEN.
//   - ev_end alone -> IDLE.
//   - ev_start without ev_end -> set proto_err, ignore it, keep the original record.
// - Record layout: packed, MSB-first: instr | addr | t_start | t_end.
//   - RECORD_W = INSTR_DATA_WIDTH + DATA_ADDR_WIDTH + 2*TIME_WIDTH.
//   - BEATS = ceil(RECORD_W / TDATA_WIDTH); the last beat is zero-padded in its LSBs.
// - Push: written at the clock edge of the ev_end cycle.
//   - The first beat appears with m_tvalid=1 no earlier than the following cycle: push-to-tvalid latency = 1 cycle.
// - Full: a push is dropped only if the FIFO is full and no pop completes in the same cycle.
//   - A pop completes when the last beat is accepted; a push in that cycle is accepted.
//   - A drop sets overflow; the FSM still transitions normally.
// - Stream: a beat transfers when m_tvalid && m_tready.
//   - m_tdata and m_tlast hold stable while m_tvalid && !m_tready.
//   - m_tvalid never drops before its beat is accepted.
//   - m_tlast=1 exactly on beat BEATS-1.
//   - The beat index advances on transfer; the FIFO pops on the last-beat transfer.
//   - Back-to-back records stream with no idle cycle.
// - Registered output; no combinational path from m_tready to m_tvalid.
// CONFIGURATION
// - GOURAM_TRACE_DROP_CNT_EN defined: adds the drop_count port; increments on each dropped record and saturates at 16'hFFFF.
// - Not defined: no drop_count port or logic; only the sticky overflow flag reports drops.
// STRUCTURE
// - Package gouram_datatypes:
//   - add TIME_WIDTH default;
//   - typedef trace_state_e {IDLE, OPEN};
//   - function trace_beats(record_w, tdata_w) = ceil division;
//   - parametrised record pack/unpack helpers beside trace_format.
// - Sub-module gouram_trace_fifo: synchronous FIFO, WIDTH/DEPTH parameters, push/pop/full/empty, async active-low reset.
// - Top level: timestamp counter, FSM, serializer.
// TESTING
// - T1, default parameters: reset, then ev_start (instr=32'h00A12023, addr=32'h1000_0040) at ts=5 and ev_end at ts=9, m_tready=1.
//   -> 4 beats: 00A12023, 10000040, 00000005, 00000009; tlast on beat 4.
// - T2: ev_start/ev_end together at ts=20 while OPEN (started at ts=12).
//   -> record1 t_end=20; record2 t_start=20; closed at ts=25 -> t_end=25; proto_err stays 0.
// - T3: m_tready=0; push 9 records into depth 8.
//   -> 8 stored; overflow=1; drop_count=1 (macro on).
//   -> Then m_tready=1: 32 beats, then m_tvalid=0.
// - T4: FIFO full; a 9th push in the same cycle as the last-beat pop of record 1.
//   -> push accepted; overflow stays 0.
// - T5: m_tready toggles 1010... mid-record.
//   -> no beat lost or duplicated; m_tdata stable during stalls.
// - T6: rst_n low on beat 2 of a record.
//   -> m_tvalid=0 immediately; after release, FIFO empty and timestamp restarts at 0.
//   -> ev_end while IDLE sets proto_err.

Source files
------------

// File: rtl/gouram_trace_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gouram_datatypes (package)
// Description : Shared types, default widths and helpers for the Gouram trace
//               stream: FSM state type, beat-count helper and the default
//               trace record format with pack/unpack helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package gouram_datatypes;

  localparam int DEF_INSTR_DATA_WIDTH = 32;
  localparam int DEF_DATA_ADDR_WIDTH  = 32;
  localparam int DEF_TIME_WIDTH       = 32;
  localparam int DEF_TDATA_WIDTH      = 32;
  localparam int DEF_FIFO_DEPTH       = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OPEN = 1'b1
  } trace_state_e;

  // Number of output beats needed to carry record_w bits (ceiling division).
  function automatic int trace_beats(input int record_w, input int tdata_w);
    return (record_w + tdata_w - 1) / tdata_w;
  endfunction

  // Record format at the default widths, MSB-first: instr | addr | t_start | t_end.
  typedef struct packed {
    logic [DEF_INSTR_DATA_WIDTH-1:0] instr;
    logic [DEF_DATA_ADDR_WIDTH-1:0]  addr;
    logic [DEF_TIME_WIDTH-1:0]       t_start;
    logic [DEF_TIME_WIDTH-1:0]       t_end;
  } trace_format;

  localparam int TRACE_FORMAT_W = $bits(trace_format);

  function automatic logic [TRACE_FORMAT_W-1:0] trace_pack(input trace_format rec);
    return rec;
  endfunction

  function automatic trace_format trace_unpack(input logic [TRACE_FORMAT_W-1:0] vec);
    return trace_format'(vec);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gouram_trace_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : gouram_trace_stream_if
// Description : Valid/ready beat stream carrying serialized trace records.
// Signals     : m_tvalid (beat valid), m_tready (sink accepts),
//               m_tdata [TDATA_WIDTH] (beat data), m_tlast (final beat)
// Modports    : master (trace source), slave (trace sink)
// Revision    : 1.0 - initial release
// ============================================================================
interface gouram_trace_stream_if
  import gouram_datatypes::*;
#(
  parameter int TDATA_WIDTH = DEF_TDATA_WIDTH
);

  logic                   m_tvalid;
  logic                   m_tready;
  logic [TDATA_WIDTH-1:0] m_tdata;
  logic                   m_tlast;

  modport master (
    output m_tvalid,
    output m_tdata,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tvalid,
    input  m_tdata,
    input  m_tlast,
    output m_tready
  );

endinterface
`default_nettype wire

// File: rtl/gouram_trace_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gouram_trace_fifo
// Description : Synchronous FIFO for trace records. A push is accepted when
//               the FIFO is not full, or when a pop completes in the same
//               cycle. Read data is the current head (show-ahead).
// Ports       : clk, rst_n (async active-low), push_i, wdata_i [WIDTH],
//               pop_i, rdata_o [WIDTH], full_o, empty_o
// Revision    : 1.0 - initial release
// ============================================================================
module gouram_trace_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_pop;
  logic             do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // When full, the slot being pushed into is the one being popped this cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/gouram_trace_stream.sv
`default_nettype none
// ============================================================================
// Module      : gouram_trace_stream
// Description : Builds trace records {instr, addr, t_start, t_end} from
//               start/end events, timestamps them with a free-running
//               counter, buffers them in a FIFO and emits each record as
//               BEATS beats of TDATA_WIDTH on a valid/ready stream.
// Ports       : clk, rst_n (async active-low)
//               ev_start, ev_instr, ev_addr, ev_end   - event inputs
//               trace_m (gouram_trace_stream_if.master) - beat stream
//               overflow  - sticky, a record was dropped (FIFO full)
//               proto_err - sticky, ev_start while OPEN or ev_end while IDLE
//               drop_count [16] - saturating drop counter
// Config      : GOURAM_TRACE_DROP_CNT_EN adds the drop_count port and logic.
// Revision    : 1.0 - initial release
// ============================================================================
module gouram_trace_stream
  import gouram_datatypes::*;
#(
  parameter int INSTR_DATA_WIDTH = DEF_INSTR_DATA_WIDTH,
  parameter int DATA_ADDR_WIDTH  = DEF_DATA_ADDR_WIDTH,
  parameter int TIME_WIDTH       = DEF_TIME_WIDTH,
  parameter int TDATA_WIDTH      = DEF_TDATA_WIDTH,
  parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ev_start,
  input  logic [INSTR_DATA_WIDTH-1:0] ev_instr,
  input  logic [DATA_ADDR_WIDTH-1:0]  ev_addr,
  input  logic                        ev_end,
  gouram_trace_stream_if.master       trace_m,
  output logic                        overflow,
  output logic                        proto_err
`ifdef GOURAM_TRACE_DROP_CNT_EN
  ,
  output logic [15:0]                 drop_count
`endif
);

  localparam int RECORD_W = INSTR_DATA_WIDTH + DATA_ADDR_WIDTH + 2*TIME_WIDTH;
  localparam int BEATS    = trace_beats(RECORD_W, TDATA_WIDTH);
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PADDED_W = BEATS * TDATA_WIDTH;
  localparam int PAD_BITS = PADDED_W - RECORD_W;

  // --------------------------------------------------------------------------
  // Timestamp
  // --------------------------------------------------------------------------
  logic [TIME_WIDTH-1:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + TIME_WIDTH'(1);
  end

  // --------------------------------------------------------------------------
  // Record builder FSM
  // --------------------------------------------------------------------------
  trace_state_e                state_q;
  logic [INSTR_DATA_WIDTH-1:0] instr_q;
  logic [DATA_ADDR_WIDTH-1:0]  addr_q;
  logic [TIME_WIDTH-1:0]       t_start_q;
  logic                        proto_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      addr_q      <= '0;
      t_start_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ev_start) begin
            state_q   <= OPEN;
            instr_q   <= ev_instr;
            addr_q    <= ev_addr;
            t_start_q <= ts_q;
          end else if (ev_end) begin
            proto_err_q <= 1'b1;
          end
        end
        OPEN: begin
          if (ev_end) begin
            // Simultaneous start re-opens immediately with the same timestamp.
            if (ev_start) begin
              instr_q   <= ev_instr;
              addr_q    <= ev_addr;
              t_start_q <= ts_q;
            end else begin
              state_q <= IDLE;
            end
          end else if (ev_start) begin
            proto_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign proto_err = proto_err_q;

  // --------------------------------------------------------------------------
  // Record FIFO
  // --------------------------------------------------------------------------
  logic                push_w;
  logic [RECORD_W-1:0] record_w;
  logic [RECORD_W-1:0] head_w;
  logic                fifo_full_w;
  logic                fifo_empty_w;
  logic                pop_w;
  logic                drop_w;

  assign push_w   = (state_q == OPEN) && ev_end;
  assign record_w = {instr_q, addr_q, t_start_q, ts_q};

  gouram_trace_fifo #(
    .WIDTH (RECORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_w),
    .wdata_i (record_w),
    .pop_i   (pop_w),
    .rdata_o (head_w),
    .full_o  (fifo_full_w),
    .empty_o (fifo_empty_w)
  );

  assign drop_w = push_w && fifo_full_w && !pop_w;

  logic overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      overflow_q <= 1'b0;
    else if (drop_w) overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;

`ifdef GOURAM_TRACE_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (drop_w && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  // --------------------------------------------------------------------------
  // Serializer
  // The head record lives in FIFO storage and stays put until its last beat
  // is accepted, so beats are selected from registered state only: tvalid
  // depends on occupancy, never on m_tready, and data holds during stalls.
  // --------------------------------------------------------------------------
  logic [BEAT_W-1:0]   beat_q;
  logic [BEAT_W-1:0]   beat_d;
  logic                xfer_w;
  logic                last_w;
  logic [PADDED_W-1:0] padded_w;
  logic [PADDED_W-1:0] shifted_w;

  assign xfer_w = trace_m.m_tvalid && trace_m.m_tready;
  assign last_w = (beat_q == BEAT_W'(BEATS - 1));
  assign pop_w  = xfer_w && last_w;

  always_comb begin
    beat_d = beat_q;
    if (xfer_w) beat_d = last_w ? '0 : beat_q + BEAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_q <= '0;
    else        beat_q <= beat_d;
  end

  // Left-align the record so the zero padding lands in the last beat's LSBs.
  assign padded_w  = PADDED_W'(head_w) << PAD_BITS;
  assign shifted_w = padded_w << (beat_q * TDATA_WIDTH);

  assign trace_m.m_tvalid = !fifo_empty_w;
  assign trace_m.m_tdata  = fifo_empty_w ? '0 : shifted_w[PADDED_W-1 -: TDATA_WIDTH];
  assign trace_m.m_tlast  = !fifo_empty_w && last_w;

endmodule
`default_nettype wire

// File: tb/tb_gouram_trace_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_gouram_trace_stream
// Description : Self-checking bench for gouram_trace_stream. A queue-based
//               reference model of records and beats predicts the stream,
//               the sticky flags and (with GOURAM_TRACE_DROP_CNT_EN) the drop
//               counter every cycle; directed scenarios add fixed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gouram_trace_stream;

  localparam int BEATS = 4;
  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        ev_start;
  logic [31:0] ev_instr;
  logic [31:0] ev_addr;
  logic        ev_end;
  logic        overflow;
  logic        proto_err;
`ifdef GOURAM_TRACE_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  gouram_trace_stream_if #(.TDATA_WIDTH(32)) tr_if ();

  gouram_trace_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ev_start  (ev_start),
    .ev_instr  (ev_instr),
    .ev_addr   (ev_addr),
    .ev_end    (ev_end),
    .trace_m   (tr_if),
    .overflow  (overflow),
    .proto_err (proto_err)
`ifdef GOURAM_TRACE_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: records as whole tuples in a bounded queue
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] ts0;
    logic [31:0] ts1;
  } rec_t;

  rec_t        mq[$];
  int          m_beat;
  bit          m_open;
  rec_t        m_cur;
  bit          m_ovf;
  bit          m_perr;
  int          m_drops;
  logic [31:0] m_ts;

  logic [32:0] cap[$];   // {tlast, tdata} of every beat accepted by the sink

  function automatic logic [31:0] beat_word(input rec_t r, input int k);
    case (k)
      0:       return r.instr;
      1:       return r.addr;
      2:       return r.ts0;
      default: return r.ts1;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_beat  = 0;
    m_open  = 0;
    m_ovf   = 0;
    m_perr  = 0;
    m_drops = 0;
    m_ts    = '0;
  endtask

  // One clock cycle: compare outputs, drive inputs, advance model, clock.
  task automatic step(input bit s, input bit e, input logic [31:0] ins,
                      input logic [31:0] ad, input bit rdy);
    bit   exp_v;
    bit   xfer;
    bit   pop;
    rec_t nr;
    exp_v = (mq.size() > 0);
    check_eq("tvalid", {63'd0, tr_if.m_tvalid}, {63'd0, exp_v});
    if (exp_v) begin
      check_eq("tdata", {32'd0, tr_if.m_tdata}, {32'd0, beat_word(mq[0], m_beat)});
      check_eq("tlast", {63'd0, tr_if.m_tlast}, {63'd0, (m_beat == BEATS-1)});
    end else begin
      check_eq("tdata_idle", {32'd0, tr_if.m_tdata}, 64'd0);
      check_eq("tlast_idle", {63'd0, tr_if.m_tlast}, 64'd0);
    end
    check_eq("overflow", {63'd0, overflow}, {63'd0, m_ovf});
    check_eq("proto_err", {63'd0, proto_err}, {63'd0, m_perr});
`ifdef GOURAM_TRACE_DROP_CNT_EN
    check_eq("drop_count", {48'd0, drop_count}, 64'(m_drops));
`endif
    ev_start       = s;
    ev_end         = e;
    ev_instr       = ins;
    ev_addr        = ad;
    tr_if.m_tready = rdy;
    if (tr_if.m_tvalid && rdy) cap.push_back({tr_if.m_tlast, tr_if.m_tdata});

    xfer = exp_v && rdy;
    pop  = xfer && (m_beat == BEATS-1);
    nr.instr = m_cur.instr;
    nr.addr  = m_cur.addr;
    nr.ts0   = m_cur.ts0;
    nr.ts1   = m_ts;
    if (xfer) m_beat = pop ? 0 : m_beat + 1;
    if (pop) void'(mq.pop_front());
    if (m_open && e) begin
      if (mq.size() < DEPTH) mq.push_back(nr);
      else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
    if (!m_open) begin
      if (s) begin
        m_open = 1;
        m_cur.instr = ins;
        m_cur.addr  = ad;
        m_cur.ts0   = m_ts;
      end else if (e) m_perr = 1;
    end else begin
      if (e) begin
        if (s) begin
          m_cur.instr = ins;
          m_cur.addr  = ad;
          m_cur.ts0   = m_ts;
        end else m_open = 0;
      end else if (s) m_perr = 1;
    end
    m_ts = m_ts + 32'd1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    ev_start       = 1'b0;
    ev_end         = 1'b0;
    ev_instr       = '0;
    ev_addr        = '0;
    tr_if.m_tready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cap.delete();
  endtask

  task automatic check_cap(input string tag, input int k, input logic [32:0] exp);
    if (k < cap.size()) check_eq(tag, {31'd0, cap[k]}, {31'd0, exp});
    else                check_eq(tag, 64'hDEAD_0000, {31'd0, exp});
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    rst_n          = 1'b0;
    ev_start       = 1'b0;
    ev_end         = 1'b0;
    ev_instr       = '0;
    ev_addr        = '0;
    tr_if.m_tready = 1'b0;

    // T1: single record, start at ts=5, end at ts=9
    do_reset();
    check_eq("T1 reset tvalid", {63'd0, tr_if.m_tvalid}, 64'd0);
    check_eq("T1 reset tdata", {32'd0, tr_if.m_tdata}, 64'd0);
    idle(5, 1'b1);
    step(1'b1, 1'b0, 32'h00A12023, 32'h1000_0040, 1'b1);
    idle(3, 1'b1);
    step(1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
    idle(6, 1'b1);
    check_eq("T1 beats", 64'(cap.size()), 64'd4);
    check_cap("T1 beat1", 0, {1'b0, 32'h00A12023});
    check_cap("T1 beat2", 1, {1'b0, 32'h1000_0040});
    check_cap("T1 beat3", 2, {1'b0, 32'h0000_0005});
    check_cap("T1 beat4", 3, {1'b1, 32'h0000_0009});

    // T2: close and re-open in the same cycle
    do_reset();
    idle(12, 1'b1);
    step(1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222, 1'b1);
    idle(7, 1'b1);
    step(1'b1, 1'b1, 32'h3333_3333, 32'h4444_4444, 1'b1);
    idle(4, 1'b1);
    step(1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
    idle(10, 1'b1);
    check_eq("T2 beats", 64'(cap.size()), 64'd8);
    check_cap("T2 r1 tstart", 2, {1'b0, 32'd12});
    check_cap("T2 r1 tend", 3, {1'b1, 32'd20});
    check_cap("T2 r2 instr", 4, {1'b0, 32'h3333_3333});
    check_cap("T2 r2 tstart", 6, {1'b0, 32'd20});
    check_cap("T2 r2 tend", 7, {1'b1, 32'd25});
    check_eq("T2 proto_err", {63'd0, proto_err}, 64'd0);

    // T3: nine records into an eight-deep FIFO with the sink stalled
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, $urandom, $urandom, 1'b0);
      step(1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
    end
    check_eq("T3 overflow", {63'd0, overflow}, 64'd1);
`ifdef GOURAM_TRACE_DROP_CNT_EN
    check_eq("T3 drop_count", {48'd0, drop_count}, 64'd1);
`endif
    cap.delete();
    idle(40, 1'b1);
    check_eq("T3 beats", 64'(cap.size()), 64'd32);
    check_eq("T3 drained", {63'd0, tr_if.m_tvalid}, 64'd0);

    // T4: push into a full FIFO in the cycle the head record pops
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, $urandom, $urandom, 1'b0);
      step(1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
    end
    step(1'b1, 1'b0, 32'h9999_9999, 32'h9999_0000, 1'b0);
    idle(3, 1'b1);
    step(1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
    check_eq("T4 overflow", {63'd0, overflow}, 64'd0);
    idle(40, 1'b1);
    check_eq("T4 beats", 64'(cap.size()), 64'd36);
    check_cap("T4 last instr", 32, {1'b0, 32'h9999_9999});

    // T5: sink ready toggling mid-record
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, $urandom, $urandom, 1'b0);
      step(1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
    end
    cap.delete();
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 32'd0, 32'd0, (i % 2) == 0);
    check_eq("T5 beats", 64'(cap.size()), 64'd12);

    // T6: asynchronous reset during beat 2 of a record
    do_reset();
    step(1'b1, 1'b0, 32'hABCD_0001, 32'hABCD_0002, 1'b1);
    step(1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    #2 rst_n = 1'b0;
    ev_start = 1'b0;
    ev_end   = 1'b0;
    #1;
    check_eq("T6 tvalid in reset", {63'd0, tr_if.m_tvalid}, 64'd0);
    check_eq("T6 tlast in reset", {63'd0, tr_if.m_tlast}, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cap.delete();
    idle(3, 1'b1);
    step(1'b1, 1'b0, 32'h5555_0001, 32'h5555_0002, 1'b1);
    step(1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
    idle(6, 1'b1);
    check_eq("T6 beats", 64'(cap.size()), 64'd4);
    check_cap("T6 tstart", 2, {1'b0, 32'd3});
    check_cap("T6 tend", 3, {1'b1, 32'd4});
    step(1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
    check_eq("T6 proto_err", {63'd0, proto_err}, 64'd1);

    // Randomized traffic with periodic sink stalls
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit rdy;
      rdy = (((i / 200) % 3) == 1) ? 1'b0 : (($urandom % 4) != 0);
      step(($urandom % 3) == 0, ($urandom % 3) == 0, $urandom, $urandom, rdy);
    end
    idle(60, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
